// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - program buffer that issues stored instruction words one per cycle
// Optional multi-pass looping is built when SEQUENCER_LOOP_EN is defined.
module instruction_sequencer #(
  parameter int          DEPTH           = 16,
  parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_00FF
) (
  input  logic                       clock_in,
  input  logic                       reset_in,
  input  logic                       load_valid_in,
  input  logic [31:0]                load_data_in,
  output logic                       load_ready_out,
  input  logic                       clear_in,
  input  logic                       start_in,
  input  logic                       abort_in,
`ifdef SEQUENCER_LOOP_EN
  input  logic [3:0]                 loop_count_in,
`endif
  output logic [31:0]                current_instruction_out,
  output logic                       instruction_valid_out,
  output logic [$clog2(DEPTH)-1:0]   pc_out,
  output logic [$clog2(DEPTH):0]     program_length_out,
  output logic                       busy_out,
  output logic                       done_out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [31:0]   buffer [DEPTH];

  logic          load_fire;
  logic          last_pass;
  logic [AW-1:0] last_idx;
  logic [AW-1:0] pc_inc;

`ifdef SEQUENCER_LOOP_EN
  logic [3:0] pass_q, pass_d;
  assign last_pass = (pass_q == 4'd0);
`else
  assign last_pass = 1'b1;
`endif

  assign load_ready_out = (state_q == IDLE) && (len_q < (AW+1)'(DEPTH)) && !clear_in && !start_in;
  assign load_fire      = load_valid_in && load_ready_out;
  // Truncation makes a full buffer (len == DEPTH) map to index DEPTH-1.
  assign last_idx       = AW'(len_q - (AW+1)'(1));
  assign pc_inc         = pc_q + AW'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    instr_d = NOP_INSTRUCTION;
    valid_d = 1'b0;
`ifdef SEQUENCER_LOOP_EN
    pass_d  = pass_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_in) begin
          len_d = '0;
        end else if (start_in && (len_q != '0)) begin
          state_d = RUN;
          pc_d    = '0;
          instr_d = buffer[0];
          valid_d = 1'b1;
`ifdef SEQUENCER_LOOP_EN
          pass_d  = loop_count_in;
`endif
        end else if (load_fire) begin
          len_d = len_q + (AW+1)'(1);
        end
      end
      RUN: begin
        if (abort_in) begin
          state_d = IDLE;
        end else if (pc_q == last_idx) begin
          if (last_pass) begin
            state_d = DONE;
          end else begin
            pc_d    = '0;
            instr_d = buffer[0];
            valid_d = 1'b1;
`ifdef SEQUENCER_LOOP_EN
            pass_d  = pass_q - 4'd1;
`endif
          end
        end else begin
          pc_d    = pc_inc;
          instr_d = buffer[pc_inc];
          valid_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      instr_q <= NOP_INSTRUCTION;
      valid_q <= 1'b0;
`ifdef SEQUENCER_LOOP_EN
      pass_q  <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef SEQUENCER_LOOP_EN
      pass_q  <= pass_d;
`endif
    end
  end

  // Program storage is deliberately left out of reset.
  always_ff @(posedge clock_in) begin
    if (load_fire) begin
      buffer[len_q[AW-1:0]] <= load_data_in;
    end
  end

  assign current_instruction_out = instr_q;
  assign instruction_valid_out   = valid_q;
  assign pc_out                  = pc_q;
  assign program_length_out      = len_q;
  assign busy_out                = (state_q == RUN);
  assign done_out                = (state_q == DONE);

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
// Loop scenario is included when SEQUENCER_LOOP_EN is defined.
module tb_instruction_sequencer;

  localparam int          DEPTH = 16;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_00FF;

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic          load_valid_in;
  logic [31:0]   load_data_in;
  logic          load_ready_out;
  logic          clear_in;
  logic          start_in;
  logic          abort_in;
  logic [3:0]    loop_count_in;
  logic [31:0]   current_instruction_out;
  logic          instruction_valid_out;
  logic [AW-1:0] pc_out;
  logic [AW:0]   program_length_out;
  logic          busy_out;
  logic          done_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_in = ~clock_in;

  instruction_sequencer #(.DEPTH(DEPTH), .NOP_INSTRUCTION(NOP)) dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .load_valid_in           (load_valid_in),
    .load_data_in            (load_data_in),
    .load_ready_out          (load_ready_out),
    .clear_in                (clear_in),
    .start_in                (start_in),
    .abort_in                (abort_in),
`ifdef SEQUENCER_LOOP_EN
    .loop_count_in           (loop_count_in),
`endif
    .current_instruction_out (current_instruction_out),
    .instruction_valid_out   (instruction_valid_out),
    .pc_out                  (pc_out),
    .program_length_out      (program_length_out),
    .busy_out                (busy_out),
    .done_out                (done_out)
  );

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b0; load_valid_in = 1'b0; load_data_in = '0; clear_in = 1'b0;
    start_in = 1'b0; abort_in = 1'b0; loop_count_in = 4'd0;
    #12;
    n_checks++; if (current_instruction_out !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", current_instruction_out, NOP); end
    n_checks++; if (instruction_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instruction_valid_out); end
    n_checks++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", busy_out, done_out); end
    n_checks++; if (program_length_out !== '0 || pc_out !== '0) begin n_fail++; $display("FAIL reset_len_pc: got %0d/%0d expected 0/0", program_length_out, pc_out); end
    n_checks++; if (load_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", load_ready_out); end
    reset_in = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] w [3];
    w[0] = 32'h0102_0300; w[1] = 32'h0201_0400; w[2] = 32'h0000_0005;
    for (int i = 0; i < 3; i++) begin
      load_valid_in = 1'b1; load_data_in = w[i];
      tick();
    end
    load_valid_in = 1'b0;
    n_checks++; if (program_length_out !== 5'd3) begin n_fail++; $display("FAIL basic_len: got %0d expected 3", program_length_out); end
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (current_instruction_out !== w[i]) begin n_fail++; $display("FAIL basic_instr%0d: got %h expected %h", i, current_instruction_out, w[i]); end
      n_checks++; if (pc_out !== AW'(i)) begin n_fail++; $display("FAIL basic_pc%0d: got %0d expected %0d", i, pc_out, i); end
      n_checks++; if (instruction_valid_out !== 1'b1 || busy_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid%0d: got %b/%b expected 1/1", i, instruction_valid_out, busy_out); end
      tick();
    end
    n_checks++; if (done_out !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done_out); end
    n_checks++; if (current_instruction_out !== NOP || instruction_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_done_nop: got %h/%b expected %h/0", current_instruction_out, instruction_valid_out, NOP); end
    tick();
    n_checks++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got done %b busy %b expected 0 0", done_out, busy_out); end
    n_checks++; if (program_length_out !== 5'd3 || load_ready_out !== 1'b1) begin n_fail++; $display("FAIL basic_retain: got len %0d ready %b expected 3 1", program_length_out, load_ready_out); end
  endtask

  task automatic test_clear_priority();
    clear_in = 1'b1; load_valid_in = 1'b1; load_data_in = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (load_ready_out !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b expected 0", load_ready_out); end
    tick();
    clear_in = 1'b0; load_valid_in = 1'b0;
    n_checks++; if (program_length_out !== '0) begin n_fail++; $display("FAIL clear_len: got %0d expected 0", program_length_out); end
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    n_checks++; if (busy_out !== 1'b0 || instruction_valid_out !== 1'b0) begin n_fail++; $display("FAIL empty_start: got busy %b valid %b expected 0 0", busy_out, instruction_valid_out); end
  endtask

  task automatic test_fill();
    int accepted = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      load_valid_in = 1'b1; load_data_in = 32'hA000_0000 + i;
      #1;
      if (load_ready_out === 1'b1) accepted++;
      n_checks++; if (load_ready_out !== (i < DEPTH)) begin n_fail++; $display("FAIL fill_ready%0d: got %b expected %b", i, load_ready_out, (i < DEPTH)); end
      @(posedge clock_in); #1;
    end
    load_valid_in = 1'b0;
    n_checks++; if (accepted !== DEPTH) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", accepted, DEPTH); end
    n_checks++; if (program_length_out !== (AW+1)'(DEPTH)) begin n_fail++; $display("FAIL fill_len: got %0d expected %0d", program_length_out, DEPTH); end
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (current_instruction_out !== 32'hA000_0000 + i || pc_out !== AW'(i)) begin n_fail++; $display("FAIL fill_issue%0d: got %h pc %0d expected %h pc %0d", i, current_instruction_out, pc_out, 32'hA000_0000 + i, i); end
      tick();
    end
    n_checks++; if (done_out !== 1'b1 || instruction_valid_out !== 1'b0) begin n_fail++; $display("FAIL fill_done: got done %b valid %b expected 1 0", done_out, instruction_valid_out); end
    tick();
  endtask

  task automatic test_abort();
    do_clear();
    for (int i = 0; i < 4; i++) begin
      load_valid_in = 1'b1; load_data_in = 32'hB000_0000 + i;
      tick();
    end
    load_valid_in = 1'b0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    n_checks++; if (current_instruction_out !== 32'hB000_0001) begin n_fail++; $display("FAIL abort_pre: got %h expected b0000001", current_instruction_out); end
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    n_checks++; if (instruction_valid_out !== 1'b0 || current_instruction_out !== NOP) begin n_fail++; $display("FAIL abort_nop: got %h/%b expected %h/0", current_instruction_out, instruction_valid_out, NOP); end
    n_checks++; if (busy_out !== 1'b0 || done_out !== 1'b0) begin n_fail++; $display("FAIL abort_state: got busy %b done %b expected 0 0", busy_out, done_out); end
    tick();
    n_checks++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL abort_nodone: got %b expected 0", done_out); end
  endtask

  task automatic test_back_to_back();
    start_in = 1'b1;
    tick();
    clear_in = 1'b1; load_valid_in = 1'b1; load_data_in = 32'hDEAD_0000;
    #1;
    n_checks++; if (load_ready_out !== 1'b0) begin n_fail++; $display("FAIL run_ready: got %b expected 0", load_ready_out); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (current_instruction_out !== 32'hB000_0000 + i) begin n_fail++; $display("FAIL rerun_issue%0d: got %h expected %h", i, current_instruction_out, 32'hB000_0000 + i); end
      if (i == 3) begin start_in = 1'b0; clear_in = 1'b0; load_valid_in = 1'b0; end
      tick();
    end
    n_checks++; if (done_out !== 1'b1) begin n_fail++; $display("FAIL rerun_done: got %b expected 1", done_out); end
    tick();
    n_checks++; if (program_length_out !== 5'd4) begin n_fail++; $display("FAIL rerun_len: got %0d expected 4", program_length_out); end
  endtask

`ifdef SEQUENCER_LOOP_EN
  task automatic test_loop();
    do_clear();
    load_valid_in = 1'b1; load_data_in = 32'hC000_0000;
    tick();
    load_data_in = 32'hC000_0001;
    tick();
    load_valid_in = 1'b0;
    loop_count_in = 4'd2; start_in = 1'b1;
    tick();
    start_in = 1'b0; loop_count_in = 4'd0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (current_instruction_out !== 32'hC000_0000 + (i % 2) || instruction_valid_out !== 1'b1 || done_out !== 1'b0) begin n_fail++; $display("FAIL loop_issue%0d: got %h v%b d%b expected %h v1 d0", i, current_instruction_out, instruction_valid_out, done_out, 32'hC000_0000 + (i % 2)); end
      tick();
    end
    n_checks++; if (done_out !== 1'b1) begin n_fail++; $display("FAIL loop_done: got %b expected 1", done_out); end
    tick();
    n_checks++; if (done_out !== 1'b0) begin n_fail++; $display("FAIL loop_single: got %b expected 0", done_out); end
  endtask
`endif

  task automatic test_async_reset();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    #2;
    reset_in = 1'b0;
    #1;
    n_checks++; if (current_instruction_out !== NOP || instruction_valid_out !== 1'b0) begin n_fail++; $display("FAIL areset_out: got %h/%b expected %h/0", current_instruction_out, instruction_valid_out, NOP); end
    n_checks++; if (busy_out !== 1'b0 || done_out !== 1'b0 || program_length_out !== '0 || pc_out !== '0) begin n_fail++; $display("FAIL areset_state: got b%b d%b len %0d pc %0d expected 0 0 0 0", busy_out, done_out, program_length_out, pc_out); end
    tick();
    reset_in = 1'b1;
    tick();
    n_checks++; if (busy_out !== 1'b0 || done_out !== 1'b0 || program_length_out !== '0 || load_ready_out !== 1'b1) begin n_fail++; $display("FAIL areset_after: got b%b d%b len %0d r%b expected 0 0 0 1", busy_out, done_out, program_length_out, load_ready_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear_priority();
    test_fill();
    test_abort();
    test_back_to_back();
`ifdef SEQUENCER_LOOP_EN
    test_loop();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
